// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// {i_hi, i_lo} is the product (multiply) or {remainder, dividend/quotient} (divide).
module muldiv_iter_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
    w_shifted = {i_hi, i_lo[XLEN-1]};
    w_diff    = w_shifted - {1'b0, i_opnd};
    o_hi      = w_sum[XLEN:1];
    o_lo      = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_is_div) begin
      // A borrow out of the trial subtract means the divisor did not fit.
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shifted[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude iteration over XLEN cycles,
// sign fix-up in FIX, one-cycle done pulse with registered result and rd tag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  localparam int unsigned      CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo, r_opnd, r_result;
  logic [2:0]        r_op;
  logic [RD_W-1:0]   r_rd, r_rd_out;
  logic              r_neg, r_neg_rem;

  logic              w_a_neg, w_b_neg, w_accept, w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_fast_res, w_fix_res;
  logic [XLEN-1:0]   w_step_hi, w_step_lo, w_quot, w_rem;
  logic [2*XLEN-1:0] w_prod;

  muldiv_iter_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_is_div(r_op[2]),
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .i_opnd  (r_opnd),
    .o_hi    (w_step_hi),
    .o_lo    (w_step_lo)
  );

  // Issue-side decode: signedness, magnitudes and the short-circuit cases.
  always_comb begin
    w_a_neg    = rs1[XLEN-1] && (funct3 != OP_MULHU) && (funct3 != OP_DIVU) &&
                 (funct3 != OP_REMU);
    w_b_neg    = rs2[XLEN-1] && (funct3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    w_abs_a    = w_a_neg ? -rs1 : rs1;
    w_abs_b    = w_b_neg ? -rs2 : rs2;
    w_accept   = (r_state == StIdle) && start && !flush;
    w_div_zero = funct3[2] && (rs2 == '0);
    w_ovf      = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                 (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    w_fast     = w_div_zero || w_ovf;
    w_fast_res = funct3[1] ? rs1 : '1;
    if (w_ovf) w_fast_res = funct3[1] ? '0 : rs1;
  end

  always_comb begin
    w_prod    = {r_hi, r_lo};
    if (r_neg) w_prod = -w_prod;
    w_quot    = r_neg ? -r_lo : r_lo;
    w_rem     = r_neg_rem ? -r_hi : r_hi;
    w_fix_res = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:           w_fix_res = w_prod[XLEN-1:0];
      OP_DIV, OP_DIVU:  w_fix_res = w_quot;
      OP_REM, OP_REMU:  w_fix_res = w_rem;
      default:          w_fix_res = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (start) w_state_d = w_fast ? StDone : StRun;
      StRun:   if (r_cnt == CNT_LAST) w_state_d = StFix;
      StFix:   w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (flush) w_state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op      <= funct3;
        r_rd      <= rd_in;
        r_neg     <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_cnt     <= '0;
        r_hi      <= '0;
        // Divide keeps the divisor in r_opnd; multiply keeps the multiplicand.
        r_opnd    <= funct3[2] ? w_abs_b : w_abs_a;
        r_lo      <= funct3[2] ? w_abs_a : w_abs_b;
        if (w_fast) begin
          r_result <= w_fast_res;
          r_rd_out <= rd_in;
        end
      end else if ((r_state == StRun) && !flush) begin
        r_hi  <= w_step_hi;
        r_lo  <= w_step_lo;
        r_cnt <= r_cnt + 1'b1;
      end else if ((r_state == StFix) && !flush) begin
        r_result <= w_fix_res;
        r_rd_out <= r_rd;
      end
    end
  end

  assign busy   = (r_state == StRun) || (r_state == StFix);
  assign done   = (r_state == StDone);
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model plus directed
// and randomized operations.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      funct3 = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [RD_W-1:0] rd_in = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_out;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(
    .XLEN(XLEN),
    .RD_W(RD_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .flush (flush),
    .funct3(funct3),
    .rs1   (rs1),
    .rs2   (rs2),
    .rd_in (rd_in),
    .busy  (busy),
    .done  (done),
    .result(result),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the M-extension rules, done in 64-bit.
  function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    return f[2] && ((b == 0) ||
           (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle model: m_cnt = cycles left in the current op, done on the last one.
  int              m_cnt;
  logic [31:0]     m_res, m_pend_res;
  logic [RD_W-1:0] m_rd, m_pend_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_res <= '0;
      m_rd  <= '0;
    end else if (flush) begin
      m_cnt <= 0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend_res <= ref_calc(funct3, rs1, rs2);
        m_pend_rd  <= rd_in;
        if (is_fast(funct3, rs1, rs2)) begin
          m_cnt <= 1;
          m_res <= ref_calc(funct3, rs1, rs2);
          m_rd  <= rd_in;
        end else begin
          m_cnt <= XLEN + 2;
        end
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_res <= m_pend_res;
        m_rd  <= m_pend_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, m_cnt > 1});
      chk("done", {31'd0, done}, {31'd0, m_cnt == 1});
      chk("result", result, m_res);
      chk("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [RD_W-1:0] rd, output int lat, output int nbusy);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within %0d cycles for funct3=%0d", lat, f);
    end
  endtask

  logic [2:0]  t_f   [13] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6,
                              3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] t_a   [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                              32'h8000_0000, 32'd7, 32'd7};
  logic [31:0] t_b   [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd0, 32'd0};
  logic [31:0] t_exp [13] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd7};
  int          t_lat [13] = '{34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 1};

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = $urandom_range(0, 15);
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    int lat, nbusy, ndone;
    logic [31:0] saved;
    logic [2:0]  f;
    logic [31:0] a, b;

    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Pin the model against hand-computed values.
    chk("pin_mul", ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    for (int i = 0; i < 13; i++) chk($sformatf("pin_%0d", i), ref_calc(t_f[i], t_a[i], t_b[i]),
                                     t_exp[i]);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, nbusy);
    chk("mul_latency", lat, 34);
    chk("mul_busy_cycles", nbusy, 33);
    chk("mul_result", result, 32'hFFFF_FFEB);
    chk("mul_rd_out", {27'd0, rd_out}, 32'd5);

    for (int i = 0; i < 13; i++) begin
      run_op(t_f[i], t_a[i], t_b[i], 5'(i + 1), lat, nbusy);
      chk($sformatf("dir_res_%0d", i), result, t_exp[i]);
      chk($sformatf("dir_lat_%0d", i), lat, t_lat[i]);
      chk($sformatf("dir_rd_%0d", i), {27'd0, rd_out}, i + 1);
    end

    // Flush during RUN iteration 10.
    saved = result;
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_result_kept", result, saved);
    run_op(3'd5, 32'd9, 32'd3, 5'd9, lat, nbusy);
    chk("after_flush_divu", result, 32'd3);

    // Start pulsed while busy is ignored.
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4; rd_in = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 2; c < 50; c++) begin
      @(negedge clk);
      start = (c == 5);
      rs1   = (c == 5) ? 32'd11 : 32'd3;
      if (done) ndone++;
    end
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_result", result, 32'd12);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd5; rs2 = 32'd6; rd_in = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd_out", {27'd0, rd_out}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int n = 0; n < 250; n++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_opnd();
      b = rnd_opnd();
      run_op(f, a, b, 5'($urandom_range(0, 31)), lat, nbusy);
      chk("rand_lat", lat, is_fast(f, a, b) ? 1 : XLEN + 2);
      if ($urandom_range(0, 3) == 0) begin
        funct3 = 3'($urandom_range(0, 7)); rs1 = rnd_opnd(); rs2 = rnd_opnd(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It sits directly downstream of instruction decode and consumes instructions that decode flags as M-type (funct7 = 0000001 with the R-type opcode). The issue logic presents funct3, the two source operand values and the destination register index. The unit runs a shift-add multiplier or restoring divider over XLEN cycles, then returns a one-cycle done pulse carrying the result and the rd tag for write-back. busy is used by the pipeline as a stall source.

Parameters:
XLEN, 32, operand/result width (must be >= 8, power of two)
RD_W, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  issue request, sampled only in IDLE
flush  input  1  pipeline kill; abandons any operation in flight
funct3  input  3  M-extension op select (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
rs1  input  XLEN  operand A (dividend / multiplicand)
rs2  input  XLEN  operand B (divisor / multiplier)
rd_in  input  RD_W  destination tag captured with start
busy  output  1  high while an operation is in flight (RUN, FIX)
done  output  1  one-cycle pulse; result and rd_out valid
result  output  XLEN  registered result, held until the next done
rd_out  output  RD_W  registered destination tag, held with result

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, rd_out=0; internal accumulators cleared. Takes effect immediately, including mid-operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE: start=1 and flush=0 latch funct3, rd_in, |rs1|, |rs2| and sign flags, then go to RUN. Operand signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Fast path, decided in IDLE (next state DONE, skipping RUN/FIX):
  - Divide by zero (rs2=0): DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = most-negative value, rs2 = all-ones): DIV gives rs1; REM gives 0.
- RUN: XLEN iterations, one per cycle, counter 0..XLEN-1; after the last iteration go to FIX.
  - Multiply: unsigned shift-add into a 2*XLEN product.
  - Divide: restoring, one quotient bit per cycle.
- FIX: negate the product if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Select product low (MUL) or high (MULH*), quotient or remainder.
  - Register result/rd_out, then go to DONE.
- DONE: done=1 for exactly this cycle; return to IDLE. A start in DONE is ignored (accepted only in IDLE).
- Latency: with start sampled at edge k, done is high in the cycle after edge k+XLEN+2 (XLEN+2 cycles total). Fast path: done is high the cycle after edge k+1.
- busy=1 in RUN and FIX. busy=0 in IDLE and DONE. Start while busy is ignored.
- flush: in any state it forces IDLE at the next edge; done is not asserted for the killed op. result/rd_out keep their previous values. If start and flush are high in the same cycle, flush wins.
- Arithmetic: abs() of the most-negative value is computed in XLEN+1 bits (or as unsigned XLEN) so it does not overflow. The product is 2*XLEN bits, negated in two's complement.

Decomposition:
- Shared package: funct3 op constants (OP_MUL..OP_REMU), state encoding (IDLE/RUN/FIX/DONE), default XLEN.
- One natural sub-module, muldiv_iter_step: the combinational single-iteration datapath, covering shift-add for multiply and trial-subtract/shift for divide. The FSM, operand capture and sign fix-up stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD: busy=1 for cycles 1..33, done=1 at cycle 34 with result=0xFFFFFFEB; rd_in=5 gives rd_out=5.
- MULH 0x80000000*0x80000000 → 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. Unsigned divide: DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done 1 cycle after start. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- flush during RUN iteration 10: busy=0 next cycle, no done, result unchanged. A following DIVU 9/3 completes normally with result 3.
- A start pulsed while busy is ignored: exactly one done. rst_n=0 mid-RUN: busy, done, result and rd_out are 0 immediately, without waiting for a clock edge.
